comm_send: RTL and testbench

//  Transmit-side streamer: pulls 128-bit words from an upstream standard-read FIFO and plays them out.

---
 rtl/comm_send_pkg.sv | 26 ++
 rtl/comm_send_raw_ser.sv | 30 +++
 rtl/comm_send.sv | 161 ++++++++++++++++
 tb/tb_comm_send.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/comm_send_pkg.sv
// Shared word/sample geometry and DAC idle code for the comm_send streamer.
// COMM_SEND_OFFSET_BIN_EN selects the midscale idle code used with offset-binary DAC output.
package comm_send_pkg;

  localparam int WORD_W       = 128;
  localparam int SMP_PER_WORD = 8;
  localparam int SMP_W        = 16;
  localparam int DA_W         = 6;
  localparam int RAW_W        = 6;
  localparam int RAW_CHUNKS   = 22;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [DA_W-1:0]   da_t;

  typedef struct packed {
    da_t i;
    da_t q;
  } iq_t;

`ifdef COMM_SEND_OFFSET_BIN_EN
  localparam da_t DA_IDLE = 6'h20;
`else
  localparam da_t DA_IDLE = 6'h00;
`endif

endpackage

// File: rtl/comm_send_raw_ser.sv
// Raw chunk selector: picks 6-bit chunk idx of a 128-bit word, LSB first; the last chunk carries the top 2 bits.
module comm_send_raw_ser
  import comm_send_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             en,
  input  word_t            word,
  input  logic [IDX_W-1:0] idx,
  output logic             vld,
  output logic [RAW_W-1:0] raw
);

  // Zero-extending to a whole number of chunks lets chunk 21 use the same slice as the others.
  logic [RAW_W*RAW_CHUNKS-1:0] padded;

  assign padded = {{(RAW_W*RAW_CHUNKS-WORD_W){1'b0}}, word};

  always_comb begin
    vld = 1'b0;
    raw = '0;
    for (int j = 0; j < RAW_CHUNKS; j++) begin
      if (en && (idx == IDX_W'(j))) begin
        vld = 1'b1;
        raw = padded[RAW_W*j +: RAW_W];
      end
    end
  end

endmodule

// File: rtl/comm_send.sv
// comm_send: pulls 128-bit words from a standard-read FIFO and plays each as 8 I/Q samples on da1/da2 plus a raw chunk stream.
// Build option COMM_SEND_OFFSET_BIN_EN: DAC codes become offset binary and idle is midscale.
module comm_send
  import comm_send_pkg::*;
#(
  parameter int SAMPLE_HOLD = 3
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              rd_en,
  input  logic [WORD_W-1:0] din,
  input  logic              empty,
  output logic              da_valid,
  output logic [DA_W-1:0]   da1,
  output logic [DA_W-1:0]   da2,
  output logic              valid_raw,
  output logic [RAW_W-1:0]  raw
);

  localparam int P  = SMP_PER_WORD * SAMPLE_HOLD;
  localparam int CW = $clog2(P);
  localparam int HW = $clog2(SAMPLE_HOLD);
  localparam int KW = $clog2(SMP_PER_WORD);

  function automatic da_t to_dac(input logic signed [DA_W-1:0] v);
`ifdef COMM_SEND_OFFSET_BIN_EN
    return {~v[DA_W-1], v[DA_W-2:0]};
`else
    return da_t'(v);
`endif
  endfunction

  logic             rd_en_q, rd_en_d;
  logic             rd_pending_q, rd_pending_d;
  word_t            nxt_q, nxt_d;
  logic             nxt_valid_q, nxt_valid_d;
  word_t            cur_q, cur_d;
  logic             playing_q, playing_d;
  logic [CW-1:0]    c_q, c_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [KW-1:0]    k_q, k_d;
  logic             da_valid_q, da_valid_d;
  da_t              da1_q, da1_d;
  da_t              da2_q, da2_d;
  logic             valid_raw_q, valid_raw_d;
  logic [RAW_W-1:0] raw_q, raw_d;

  logic             avail;
  logic             period_end;
  word_t            word_in;
  iq_t              smp;

  always_comb begin
    nxt_d       = nxt_q;
    nxt_valid_d = nxt_valid_q;
    cur_d       = cur_q;
    playing_d   = playing_q;
    c_d         = c_q;
    hold_d      = hold_q;
    k_d         = k_q;
    smp         = '0;

    // A word is available either from the prefetch buffer or straight off din the cycle after a read.
    avail      = nxt_valid_q || rd_pending_q;
    word_in    = nxt_valid_q ? nxt_q : din;
    period_end = !playing_q || (c_q == CW'(P-1));

    if (period_end) begin
      if (avail) begin
        playing_d   = 1'b1;
        cur_d       = word_in;
        c_d         = '0;
        hold_d      = '0;
        k_d         = '0;
        nxt_valid_d = 1'b0;
      end else begin
        playing_d = 1'b0;
      end
    end else begin
      c_d = c_q + CW'(1);
      if (hold_q == HW'(SAMPLE_HOLD-1)) begin
        hold_d = '0;
        k_d    = k_q + KW'(1);
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end

    if (rd_pending_q && !period_end) begin
      nxt_d       = din;
      nxt_valid_d = 1'b1;
    end

    rd_pending_d = rd_en_q;
    rd_en_d      = !empty && !nxt_valid_q && !rd_en_q && !rd_pending_q;

    for (int i = 0; i < SMP_PER_WORD; i++) begin
      if (k_d == KW'(i)) begin
        smp.i = cur_d[SMP_W*i+10 +: DA_W];
        smp.q = cur_d[SMP_W*i+2  +: DA_W];
      end
    end

    da_valid_d = playing_d;
    da1_d      = playing_d ? to_dac(smp.i) : DA_IDLE;
    da2_d      = playing_d ? to_dac(smp.q) : DA_IDLE;
  end

  comm_send_raw_ser #(
    .IDX_W(CW)
  ) u_raw_ser (
    .en   (playing_d),
    .word (cur_d),
    .idx  (c_d),
    .vld  (valid_raw_d),
    .raw  (raw_d)
  );

  // Output stage: every port comes straight from a flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_en_q      <= 1'b0;
      rd_pending_q <= 1'b0;
      nxt_q        <= '0;
      nxt_valid_q  <= 1'b0;
      cur_q        <= '0;
      playing_q    <= 1'b0;
      c_q          <= '0;
      hold_q       <= '0;
      k_q          <= '0;
      da_valid_q   <= 1'b0;
      da1_q        <= DA_IDLE;
      da2_q        <= DA_IDLE;
      valid_raw_q  <= 1'b0;
      raw_q        <= '0;
    end else begin
      rd_en_q      <= rd_en_d;
      rd_pending_q <= rd_pending_d;
      nxt_q        <= nxt_d;
      nxt_valid_q  <= nxt_valid_d;
      cur_q        <= cur_d;
      playing_q    <= playing_d;
      c_q          <= c_d;
      hold_q       <= hold_d;
      k_q          <= k_d;
      da_valid_q   <= da_valid_d;
      da1_q        <= da1_d;
      da2_q        <= da2_d;
      valid_raw_q  <= valid_raw_d;
      raw_q        <= raw_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign da_valid  = da_valid_q;
  assign da1       = da1_q;
  assign da2       = da2_q;
  assign valid_raw = valid_raw_q;
  assign raw       = raw_q;

endmodule

// File: tb/tb_comm_send.sv
// Bench for comm_send: FIFO model plus a play-schedule reference (word start times, sample/chunk arithmetic).
// Honours COMM_SEND_OFFSET_BIN_EN for expected DAC codes.
module tb_comm_send;

  localparam int SH = 3;
  localparam int P  = 8 * SH;
`ifdef COMM_SEND_OFFSET_BIN_EN
  localparam logic [5:0] IDLE = 6'h20;
  localparam logic [5:0] FLIP = 6'h20;
`else
  localparam logic [5:0] IDLE = 6'h00;
  localparam logic [5:0] FLIP = 6'h00;
`endif
  localparam logic [127:0] W0 = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         rd_en;
  logic [127:0] din = '0;
  logic         empty = 1'b1;
  logic         da_valid;
  logic [5:0]   da1, da2;
  logic         valid_raw;
  logic [5:0]   raw;

  comm_send #(.SAMPLE_HOLD(SH)) dut (
    .CLK(CLK), .RST(RST), .rd_en(rd_en), .din(din), .empty(empty),
    .da_valid(da_valid), .da1(da1), .da2(da2), .valid_raw(valid_raw), .raw(raw)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    longint       start;
    logic [127:0] w;
  } play_t;

  play_t        sched[$];
  logic [127:0] fifo_q[$];
  int           n_vec = 0, n_err = 0;
  longint       cyc = 0, last_end = 0, t_rd = 0, prev_rd = 0, t_mark = 0;
  bit           rd_pend = 0;
  logic [127:0] pend_w = '0;
  int           rd_cnt = 0, vr_cnt = 0, dv_cnt = 0, dv_run = 0, dv_max = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push(input logic [127:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  // One clock: compare outputs with the schedule, then advance the FIFO and schedule models.
  task automatic step();
    bit           rst_edge;
    logic         e_dv, e_vr;
    logic [5:0]   e_da1, e_da2, e_raw;
    logic [127:0] tmp;
    longint       c, k, s;
    int           fut;
    rst_edge = RST;
    @(posedge CLK);
    #1;
    cyc++;
    if (rst_edge) begin
      sched.delete();
      rd_pend  = 0;
      last_end = 0;
    end
    while (sched.size() > 0 && sched[0].start + P <= cyc) void'(sched.pop_front());
    e_dv = 1'b0; e_vr = 1'b0; e_da1 = IDLE; e_da2 = IDLE; e_raw = '0;
    if (sched.size() > 0 && sched[0].start <= cyc) begin
      c     = cyc - sched[0].start;
      k     = c / SH;
      e_dv  = 1'b1;
      tmp   = sched[0].w >> (16*k + 10);
      e_da1 = tmp[5:0] ^ FLIP;
      tmp   = sched[0].w >> (16*k + 2);
      e_da2 = tmp[5:0] ^ FLIP;
      if (c < 22) begin
        e_vr  = 1'b1;
        tmp   = sched[0].w >> (6*c);
        e_raw = tmp[5:0];
      end
    end
    chk("da_valid",  128'(da_valid),  128'(e_dv));
    chk("da1",       128'(da1),       128'(e_da1));
    chk("da2",       128'(da2),       128'(e_da2));
    chk("valid_raw", 128'(valid_raw), 128'(e_vr));
    chk("raw",       128'(raw),       128'(e_raw));
    chk("rd_en_while_empty", 128'(rd_en & empty), 128'(0));
    if (rst_edge) chk("rd_en_after_rst", 128'(rd_en), 128'(0));
    if (rd_en) begin
      fut = rd_pend ? 1 : 0;
      foreach (sched[i]) if (sched[i].start > cyc) fut++;
      chk("rd_overfetch", 128'(fut), 128'(0));
    end
    if (rd_pend) begin
      din = pend_w;
      s   = (cyc + 1 > last_end) ? cyc + 1 : last_end;
      sched.push_back('{s, pend_w});
      last_end = s + P;
      rd_pend  = 0;
    end else begin
      din = rand_word();
    end
    if (rd_en && fifo_q.size() > 0) begin
      pend_w  = fifo_q.pop_front();
      rd_pend = 1;
    end
    if (rd_en) begin
      rd_cnt++;
      prev_rd = t_rd;
      t_rd    = cyc;
    end
    empty  = (fifo_q.size() == 0);
    vr_cnt += int'(valid_raw);
    dv_cnt += int'(da_valid);
    dv_run = da_valid ? dv_run + 1 : 0;
    if (dv_run > dv_max) dv_max = dv_run;
  endtask

  task automatic wait_rd(input int lim, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (rd_en) begin
        found = 1;
        break;
      end
    end
    chk(tag, 128'(found), 128'(1));
  endtask

  initial begin
    // Reset held two cycles with a non-empty FIFO.
    push(rand_word());
    RST = 1'b1;
    step();
    step();
    chk("rst_rd_en",     128'(rd_en),     128'(0));
    chk("rst_da_valid",  128'(da_valid),  128'(0));
    chk("rst_valid_raw", 128'(valid_raw), 128'(0));
    chk("rst_da1",       128'(da1),       128'(IDLE));
    chk("rst_da2",       128'(da2),       128'(IDLE));
    chk("rst_raw",       128'(raw),       128'(0));
    fifo_q.delete();
    empty = 1'b1;
    step();
    RST = 1'b0;
    repeat (4) begin
      step();
      chk("idle_rd_en", 128'(rd_en), 128'(0));
    end

    // Single word, then underflow.
    rd_cnt = 0; vr_cnt = 0; dv_cnt = 0;
    push(W0);
    wait_rd(6, "t2_fetch");
    step();
    chk("t2_lat_t1", 128'(da_valid), 128'(0));
    step();
    chk("t2_lat_t2", 128'(da_valid), 128'(1));
    chk("t2_da1_s0", 128'(da1), 128'(6'h0C ^ FLIP));
    chk("t2_da2_s0", 128'(da2), 128'(6'h04 ^ FLIP));
    chk("t2_raw0",   128'(raw), 128'(6'h10));
    step();
    chk("t2_raw1",   128'(raw), 128'(6'h08));
    chk("t2_da1_h1", 128'(da1), 128'(6'h0C ^ FLIP));
    step();
    chk("t2_da2_h2", 128'(da2), 128'(6'h04 ^ FLIP));
    step();
    chk("t2_da1_s1", 128'(da1), 128'(6'h1D ^ FLIP));
    chk("t2_da2_s1", 128'(da2), 128'(6'h15 ^ FLIP));
    repeat (26) step();
    chk("t2_rd_count",    128'(rd_cnt),   128'(1));
    chk("t2_vraw_cycles", 128'(vr_cnt),   128'(22));
    chk("t3_dv_cycles",   128'(dv_cnt),   128'(24));
    chk("t3_da_valid",    128'(da_valid), 128'(0));
    chk("t3_da1_idle",    128'(da1),      128'(IDLE));
    chk("t3_da2_idle",    128'(da2),      128'(IDLE));
    chk("t3_rd_en",       128'(rd_en),    128'(0));

    // Three-word stream.
    rd_cnt = 0; dv_max = 0;
    repeat (3) push(rand_word());
    wait_rd(6, "t4_fetch");
    for (int i = 0; i < 100; i++) begin
      step();
      if (rd_en && rd_cnt == 3) chk("t4_rd_spacing", 128'(t_rd - prev_rd), 128'(P));
    end
    chk("t4_dv_run",   128'(dv_max), 128'(72));
    chk("t4_rd_count", 128'(rd_cnt), 128'(3));

    // Reset in the middle of a period.
    repeat (3) push(rand_word());
    wait_rd(6, "t5_fetch");
    t_mark = cyc;
    repeat (12) step();
    chk("t5_c10_live", 128'(cyc - t_mark == 12 && da_valid), 128'(1));
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("t5_da_valid", 128'(da_valid),  128'(0));
    chk("t5_vraw",     128'(valid_raw), 128'(0));
    chk("t5_da1",      128'(da1),       128'(IDLE));
    wait_rd(6, "t5_refetch");
    repeat (40) step();

    // Randomized traffic with bursts, underflow gaps and occasional resets.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < ((it < 200) ? 8 : 2) && fifo_q.size() < 4) push(rand_word());
      if (r == 99) begin
        RST = 1'b1;
        step();
        RST = 1'b0;
      end
      step();
    end
    repeat (60) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
